// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART blocks (uart_rx, uart_tx, uart_frame_parser):
//   frame parser state encoding, default sync byte, default clock/bit-rate
//   figures, the cycles-per-bit formula and the running checksum step.
//   No ports (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_OUT     = 3'd5
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int CLK_FREQ_DEF = 100;     // MHz
  localparam int BIT_RATE_DEF = 115200;  // Hz

  // Clock cycles per UART bit for a clock given in MHz.
  function automatic int cycle_per_bit(input int clk_mhz, input int bit_rate);
    return (clk_mhz * 1000000) / bit_rate;
  endfunction

  localparam int CYCLE = cycle_per_bit(CLK_FREQ_DEF, BIT_RATE_DEF);

  // Frame checksum is a plain byte-wise XOR.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
//   Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write and
//   registered read (read data appears one cycle after rd_addr).
//   Ports:
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_addr  in   read address
//     rd_data  out  registered read data
module uart_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];
  logic [7:0] rd_data_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses SYNC, CMD, LEN, PAYLOAD[LEN], CSUM frames from a uart_rx byte
//   stream and replays CMD + payload as a ready/valid beat stream.
//   Optional feature: define UART_FRAME_TIMEOUT_EN to abort a frame after
//   TIMEOUT_BYTES idle byte-times (tout_err); otherwise tout_err stays 0.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   byte strobe from uart_rx
//     in_data    in   received byte
//     in_err     in   stop-bit error strobe from uart_rx
//     out_valid  out  output beat valid
//     out_ready  in   downstream accept
//     out_data   out  beat 0 = CMD, beats 1..LEN = payload
//     out_last   out  final beat of frame
//     crc_err, len_err, frame_err, ovr_err, tout_err  out  one-cycle status pulses
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ      = CLK_FREQ_DEF,
  parameter int         BIT_RATE      = BIT_RATE_DEF,
  parameter int         MAX_LEN       = 64,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       crc_err,
  output logic       len_err,
  output logic       frame_err,
  output logic       ovr_err,
  output logic       tout_err
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frame_state_e state_r;
  logic [7:0]   cmd_r;
  logic [7:0]   len_r;
  logic [7:0]   idx_r;
  logic [7:0]   csum_r;
  logic [7:0]   beat_r;
  logic         out_valid_r;
  logic [7:0]   out_data_r;
  logic         out_last_r;
  logic         crc_err_r;
  logic         len_err_r;
  logic         frame_err_r;
  logic         ovr_err_r;
  logic         tout_err_r;

  logic         byte_s;
  logic         xfer_s;
  logic         tout_hit_s;
  logic         wr_en_s;
  logic [7:0]   rd_beat_s;
  logic [7:0]   rd_data_s;

  // A byte arriving together with a stop-bit error is discarded.
  assign byte_s = in_valid & ~in_err;
  assign xfer_s = out_valid_r & out_ready;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TOUT_CYCLES = TIMEOUT_BYTES * 10 * cycle_per_bit(CLK_FREQ, BIT_RATE);
  localparam int TW          = $clog2(TOUT_CYCLES + 1);

  logic [TW-1:0] tout_cnt_r;

  // Idle counter: runs only while a frame is partially received.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tout_cnt_r <= {TW{1'b0}};
    end else if (in_valid || (state_r == ST_HUNT) || (state_r == ST_OUT)) begin
      tout_cnt_r <= {TW{1'b0}};
    end else begin
      tout_cnt_r <= tout_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign tout_hit_s = (tout_cnt_r == TW'(TOUT_CYCLES - 1));
`else
  assign tout_hit_s = 1'b0;
`endif

  // Payload writes go straight to the buffer at the running index.
  assign wr_en_s = (state_r == ST_PAYLOAD) & byte_s;

  // Read address tracks the beat index that will be current next cycle, so the
  // registered RAM output already holds the following payload byte whenever
  // a beat transfers (beat k+1 carries buffer[k]).
  always_comb begin
    rd_beat_s = 8'd0;
    if (state_r == ST_OUT) begin
      if (xfer_s) begin
        rd_beat_s = beat_r + 8'd1;
      end else begin
        rd_beat_s = beat_r;
      end
    end else begin
      rd_beat_s = 8'd0;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (idx_r[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_beat_s[AW-1:0]),
    .rd_data (rd_data_s)
  );

  // Frame parser FSM with registered beat outputs and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      cmd_r       <= 8'd0;
      len_r       <= 8'd0;
      idx_r       <= 8'd0;
      csum_r      <= 8'd0;
      beat_r      <= 8'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      out_last_r  <= 1'b0;
      crc_err_r   <= 1'b0;
      len_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
      ovr_err_r   <= 1'b0;
      tout_err_r  <= 1'b0;
    end else begin
      crc_err_r   <= 1'b0;
      len_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
      ovr_err_r   <= 1'b0;
      tout_err_r  <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          if (byte_s && (in_data == SYNC_BYTE)) begin
            state_r <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (in_err) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
          end else if (in_valid) begin
            cmd_r   <= in_data;
            csum_r  <= in_data;
            state_r <= ST_LEN;
          end else if (tout_hit_s) begin
            tout_err_r <= 1'b1;
            state_r    <= ST_HUNT;
          end
        end
        ST_LEN: begin
          if (in_err) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
          end else if (in_valid) begin
            if (in_data > MAX_LEN_B) begin
              len_err_r <= 1'b1;
              state_r   <= ST_HUNT;
            end else begin
              len_r   <= in_data;
              idx_r   <= 8'd0;
              csum_r  <= csum_step(csum_r, in_data);
              state_r <= (in_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
            end
          end else if (tout_hit_s) begin
            tout_err_r <= 1'b1;
            state_r    <= ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          if (in_err) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
          end else if (in_valid) begin
            idx_r  <= idx_r + 8'd1;
            csum_r <= csum_step(csum_r, in_data);
            if (idx_r == (len_r - 8'd1)) begin
              state_r <= ST_CSUM;
            end
          end else if (tout_hit_s) begin
            tout_err_r <= 1'b1;
            state_r    <= ST_HUNT;
          end
        end
        ST_CSUM: begin
          if (in_err) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
          end else if (in_valid) begin
            if (in_data == csum_r) begin
              state_r     <= ST_OUT;
              beat_r      <= 8'd0;
              out_valid_r <= 1'b1;
              out_data_r  <= cmd_r;
              out_last_r  <= (len_r == 8'd0);
            end else begin
              crc_err_r <= 1'b1;
              state_r   <= ST_HUNT;
            end
          end else if (tout_hit_s) begin
            tout_err_r <= 1'b1;
            state_r    <= ST_HUNT;
          end
        end
        ST_OUT: begin
          // No backpressure upstream: bytes arriving while replaying are lost.
          if (byte_s) begin
            ovr_err_r <= 1'b1;
          end
          if (xfer_s) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= 8'd0;
              state_r     <= ST_HUNT;
            end else begin
              beat_r     <= beat_r + 8'd1;
              out_data_r <= rd_data_s;
              out_last_r <= ((beat_r + 8'd1) == len_r);
            end
          end
        end
        default: begin
          state_r <= ST_HUNT;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign crc_err   = crc_err_r;
  assign len_err   = len_err_r;
  assign frame_err = frame_err_r;
  assign ovr_err   = ovr_err_r;
  assign tout_err  = tout_err_r;

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser
Interface
REQ-001 Params: CLK_FREQ=100 (MHz); BIT_RATE=115200 (Hz); MAX_LEN=64 (max payload bytes, 1..255); SYNC_BYTE=8'hA5 (frame start); TIMEOUT_BYTES=4 (idle byte-times before abort).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  one-cycle byte strobe from uart_rx; no backpressure.
REQ-005 in_data  in  8  received byte, qualified by in_valid.
REQ-006 in_err  in  1  one-cycle stop-bit error strobe from uart_rx.
REQ-007 out_valid  out  1  output beat valid.
REQ-008 out_ready  in  1  downstream accept; beat transfers when out_valid & out_ready.
REQ-009 out_data  out  8  beat 0 = CMD, beats 1..LEN = payload.
REQ-010 out_last  out  1  marks final beat of frame.
REQ-011 crc_err, len_err, frame_err, ovr_err, tout_err  out  1 each  one-cycle status pulses.
Function
REQ-012 Frame on wire: SYNC, CMD, LEN, PAYLOAD[LEN], CSUM; CSUM = XOR of CMD, LEN and all payload bytes.
REQ-013 States HUNT, CMD, LEN, PAYLOAD, CSUM, OUT; HUNT after reset.
REQ-014 HUNT: in_valid & in_data==SYNC_BYTE -> CMD; any other byte discarded silently.
REQ-015 CMD: in_valid -> latch CMD, seed checksum, -> LEN.
REQ-016 LEN: in_valid & in_data>MAX_LEN -> len_err pulse, -> HUNT; in_data==0 -> CSUM; else -> PAYLOAD.
REQ-017 PAYLOAD: each in_valid writes buffer[idx], idx+1, XOR into checksum; after LEN-th byte -> CSUM.
REQ-018 CSUM: in_valid & match -> OUT; mismatch -> crc_err pulse, -> HUNT, nothing emitted.
REQ-019 OUT: emits LEN+1 beats; out_data/out_last stable while out_valid & ~out_ready; out_last on beat LEN (beat 0 when LEN=0); after last transfer -> HUNT.
REQ-020 First beat out_valid asserts cycle after CSUM byte accepted; back-to-back beats at full rate when out_ready held high.
REQ-021 OUT: any in_valid -> byte dropped, ovr_err pulse same cycle+1; state unaffected.
REQ-022 in_err in CMD/LEN/PAYLOAD/CSUM -> frame_err pulse, -> HUNT; in_err in HUNT/OUT ignored.
REQ-023 in_valid and in_err in same cycle: in_err wins, byte discarded.
REQ-024 Checksum and index are 8-bit; index counter wraps never (bounded by MAX_LEN check).
REQ-025 All status pulses registered, exactly one cycle wide, mutually exclusive per event.
Reset
REQ-026 rst_n low at clk edge: state=HUNT, out_valid=0, out_last=0, out_data=0, all err pulses=0, counters/checksum=0.
REQ-027 Reset mid-frame or mid-OUT abandons frame without any error pulse; buffer contents need not clear.
Configuration
REQ-028 Macro UART_FRAME_TIMEOUT_EN defined: counter runs in CMD..CSUM, clears on in_valid; reaching TIMEOUT_BYTES*10*(CLK_FREQ*1e6/BIT_RATE) cycles -> tout_err pulse, -> HUNT.
REQ-029 Macro undefined: no timeout counter synthesized, tout_err tied 0, parser waits indefinitely.
Structure
REQ-030 Package uart_pkg holds state enum, SYNC_BYTE default, CYCLE localparam formula shared with uart_rx/uart_tx.
REQ-031 Sub-module uart_frame_buf: MAX_LEN x 8 simple dual-port RAM, sync write, registered read (1-cycle latency, prefetch in OUT).
Verification
REQ-032 A5 10 02 33 44 (10^02^33^44=65) -> beats 10,33,44; out_last on 44; no err.
REQ-033 A5 20 00 20 with out_ready=1 -> single beat 20, out_last=1; A5 20 00 21 -> crc_err, no out_valid.
REQ-034 LEN=MAX_LEN+1 -> len_err after LEN byte, next valid frame parsed correctly.
REQ-035 in_err during PAYLOAD -> frame_err, state HUNT; out_ready=0 for 5 cycles in OUT -> beat held stable; byte in OUT -> ovr_err.
REQ-036 With UART_FRAME_TIMEOUT_EN: A5 10 then silence > timeout -> tout_err, HUNT; without macro: no pulse, frame completes later.
